// File: rtl/sd_loader_pkg.sv
// Shared state encoding and SD block-buffer geometry for the SD file loader.
package sd_loader_pkg;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, COPY, NEXT, DONE, ERROR} state_t;

  localparam int BLOCK_BYTES = 512;
  localparam int BUF_AW      = 9;

endpackage

// File: rtl/sd_byte_unpacker.sv
// Splits one buffer byte into 8/DATA_W consecutive DATA_W-bit slices, LSB slice first.
module sd_byte_unpacker #(
  parameter int DATA_W = 1
) (
  input  logic              clk_spi,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              load,
  input  logic [7:0]        byte_in,
  output logic [DATA_W-1:0] slice,
  output logic              valid,
  output logic              last_slice
);

  localparam int         SLICES   = 8 / DATA_W;
  localparam logic [2:0] LAST_IDX = 3'(SLICES - 1);

  logic [7:0] shift_reg;
  logic [2:0] cnt_reg;
  logic       valid_reg;

  // A load in the cycle of the last slice keeps the stream gap-free.
  always_ff @(posedge clk_spi or negedge reset_n) begin
    if (!reset_n) begin
      shift_reg <= '0;
      cnt_reg   <= '0;
      valid_reg <= 1'b0;
    end else if (clear) begin
      cnt_reg   <= '0;
      valid_reg <= 1'b0;
    end else if (load) begin
      shift_reg <= byte_in;
      cnt_reg   <= '0;
      valid_reg <= 1'b1;
    end else if (valid_reg) begin
      if (cnt_reg == LAST_IDX) begin
        valid_reg <= 1'b0;
      end else begin
        cnt_reg   <= cnt_reg + 3'd1;
        shift_reg <= shift_reg >> DATA_W;
      end
    end
  end

  assign slice      = shift_reg[DATA_W-1:0];
  assign valid      = valid_reg;
  assign last_slice = valid_reg && (cnt_reg == LAST_IDX);

endmodule

// File: rtl/sd_file_loader.sv
// Streams FILE_BLOCKS consecutive SD blocks into board RAM as DATA_W-bit words from address 0,
// stopping early once FRAME_WORDS words have been written.
module sd_file_loader
  import sd_loader_pkg::*;
#(
  parameter int FILE_BLOCKS = 128,
  parameter int DATA_W      = 1,
  parameter int ADDR_W      = 24,
  parameter int FRAME_WORDS = 480000
) (
  input  logic              clk_spi,
  input  logic              reset_n,
  input  logic [15:0]       file_id,
  input  logic              load_start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              blk_req,
  output logic [31:0]       blk_id,
  input  logic              blk_done,
  input  logic              blk_err,
  output logic [BUF_AW-1:0] buf_addr,
  input  logic [7:0]        buf_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we
);

  if (!(DATA_W == 1 || DATA_W == 2 || DATA_W == 4 || DATA_W == 8) ||
      (64'(FRAME_WORDS) > (64'd1 << ADDR_W))) begin : g_param_check
    $error("sd_file_loader: illegal DATA_W / FRAME_WORDS / ADDR_W combination");
  end

  localparam int                SLICES    = 8 / DATA_W;
  localparam logic [3:0]        LEAD_INIT = 4'(SLICES + 1);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(FRAME_WORDS - 1);
  localparam logic [BUF_AW:0]   BLK_END   = (BUF_AW + 1)'(BLOCK_BYTES);

  state_t            state_reg;
  logic [ADDR_W-1:0] word_cnt_reg;
  logic              limit_reg;
  logic [31:0]       blk_cnt_reg;
  logic [BUF_AW:0]   byte_idx_reg;
  logic              pend_reg;
  logic              arrive_reg;
  logic [3:0]        lead_reg;

  logic              accept;
  logic              issue;
  logic              write_ok;
  logic              blk_drained;
  logic              unpk_load;
  logic [DATA_W-1:0] slice;
  logic              slice_valid;
  logic              slice_last;

  assign accept    = load_start &&
                     (state_reg == IDLE || state_reg == DONE || state_reg == ERROR);
  // lead_reg: cycles until the last committed slice; a fetch issued now unpacks 3 cycles later.
  assign issue     = (state_reg == COPY) && (byte_idx_reg != BLK_END) &&
                     (lead_reg <= 4'd2) && !limit_reg;
  assign write_ok  = (state_reg == COPY) && slice_valid && !limit_reg;
  assign unpk_load = arrive_reg && (state_reg == COPY);
  assign blk_drained = (byte_idx_reg == BLK_END) && !pend_reg && !arrive_reg &&
                       (!slice_valid || slice_last);

  sd_byte_unpacker #(.DATA_W(DATA_W)) u_unpacker (
    .clk_spi   (clk_spi),
    .reset_n   (reset_n),
    .clear     (accept),
    .load      (unpk_load),
    .byte_in   (buf_data),
    .slice     (slice),
    .valid     (slice_valid),
    .last_slice(slice_last)
  );

  always_ff @(posedge clk_spi or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      blk_req      <= 1'b0;
      blk_id       <= '0;
      buf_addr     <= '0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
      ram_we       <= 1'b0;
      word_cnt_reg <= '0;
      limit_reg    <= 1'b0;
      blk_cnt_reg  <= '0;
      byte_idx_reg <= '0;
      pend_reg     <= 1'b0;
      arrive_reg   <= 1'b0;
      lead_reg     <= '0;
    end else begin
      blk_req    <= 1'b0;
      ram_we     <= 1'b0;
      pend_reg   <= 1'b0;
      arrive_reg <= pend_reg;
      // ram_addr shows the address during the write cycle, then steps past it.
      if (ram_we) ram_addr <= ram_addr + 1'b1;
      if (lead_reg != 4'd0) lead_reg <= lead_reg - 4'd1;

      if (write_ok) begin
        ram_we       <= 1'b1;
        ram_wdata    <= slice;
        word_cnt_reg <= word_cnt_reg + 1'b1;
        if (word_cnt_reg == LAST_WORD) limit_reg <= 1'b1;
      end

      if (issue) begin
        buf_addr     <= byte_idx_reg[BUF_AW-1:0];
        byte_idx_reg <= byte_idx_reg + 1'b1;
        pend_reg     <= 1'b1;
        lead_reg     <= LEAD_INIT;
      end

      case (state_reg)
        IDLE, DONE, ERROR: begin
          if (accept) begin
            state_reg    <= REQ;
            blk_id       <= 32'(file_id) * 32'(FILE_BLOCKS);
            busy         <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            blk_req      <= 1'b1;
            buf_addr     <= '0;
            ram_addr     <= '0;
            word_cnt_reg <= '0;
            limit_reg    <= 1'b0;
            blk_cnt_reg  <= '0;
          end
        end
        REQ: state_reg <= WAIT;
        WAIT: begin
          if (blk_err) begin
            state_reg <= ERROR;
            busy      <= 1'b0;
            error     <= 1'b1;
          end else if (blk_done) begin
            state_reg    <= COPY;
            byte_idx_reg <= '0;
            buf_addr     <= '0;
            lead_reg     <= '0;
          end
        end
        COPY: begin
          if (limit_reg) begin
            state_reg <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else if (blk_drained) begin
            state_reg <= NEXT;
          end
        end
        NEXT: begin
          blk_id      <= blk_id + 32'd1;
          blk_cnt_reg <= blk_cnt_reg + 32'd1;
          if (limit_reg || (blk_cnt_reg + 32'd1 == 32'(FILE_BLOCKS))) begin
            state_reg <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else begin
            state_reg <= REQ;
            blk_req   <= 1'b1;
            buf_addr  <= '0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_file_loader.sv
// Scoreboard bench: three loader configurations, each with a block-reader and buffer model.
module tb_sd_file_loader;

  localparam int NI = 3;
  localparam int P_DW [NI] = '{1, 4, 1};
  localparam int P_FB [NI] = '{2, 1, 2};
  localparam int P_FW [NI] = '{8192, 1024, 5000};
  localparam int BUDGET = 20000;

  logic clk_spi = 1'b0;
  logic reset_n = 1'b0;
  logic [NI-1:0]        load_start = '0;
  logic [NI-1:0][15:0]  file_id = '0;
  logic [NI-1:0]        busy_w, done_w, error_w, ram_we_w;
  logic [NI-1:0][23:0]  ram_addr_w;

  logic [31:0] exp_wr  [NI][$];
  logic [31:0] exp_blk [NI][$];
  int err_blk  [NI];
  int blk_seen [NI];
  int run_cur  [NI];
  int run_max  [NI];
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_spi = ~clk_spi;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] buf_byte(input int inst, input int idx);
    if (inst == 1 && idx == 0) return 8'hA5;
    return 8'(idx);
  endfunction

  for (genvar gi = 0; gi < NI; gi++) begin : g_inst
    logic                blk_req, blk_done, blk_err;
    logic [31:0]         blk_id;
    logic [8:0]          buf_addr;
    logic [7:0]          buf_data;
    logic [P_DW[gi]-1:0] ram_wdata;
    logic [7:0]          wdata8;
    bit                  rd_act, rd_fail;
    int                  rd_cnt;

    assign wdata8 = 8'(ram_wdata);

    sd_file_loader #(
      .FILE_BLOCKS(P_FB[gi]), .DATA_W(P_DW[gi]), .ADDR_W(24), .FRAME_WORDS(P_FW[gi])
    ) u_dut (
      .clk_spi   (clk_spi),
      .reset_n   (reset_n),
      .file_id   (file_id[gi]),
      .load_start(load_start[gi]),
      .busy      (busy_w[gi]),
      .done      (done_w[gi]),
      .error     (error_w[gi]),
      .blk_req   (blk_req),
      .blk_id    (blk_id),
      .blk_done  (blk_done),
      .blk_err   (blk_err),
      .buf_addr  (buf_addr),
      .buf_data  (buf_data),
      .ram_addr  (ram_addr_w[gi]),
      .ram_wdata (ram_wdata),
      .ram_we    (ram_we_w[gi])
    );

    // Block buffer: one cycle read latency.
    always @(posedge clk_spi) buf_data <= buf_byte(gi, int'(buf_addr));

    always @(negedge clk_spi) begin
      logic [31:0] e;
      blk_done = 1'b0;
      blk_err  = 1'b0;
      if (!reset_n) begin
        rd_act = 1'b0;
      end else begin
        if (rd_act) begin
          if (rd_cnt == 0) begin
            rd_act = 1'b0;
            if (rd_fail) blk_err = 1'b1;
            else         blk_done = 1'b1;
          end else begin
            rd_cnt--;
          end
        end
        if (blk_req) begin
          $display("inst %0d: blk_req blk_id=%0d", gi, blk_id);
          if (exp_blk[gi].size() == 0) check("blk_extra", blk_req, 0);
          else begin
            e = exp_blk[gi].pop_front();
            check("blk_id", blk_id, e);
          end
          rd_act  = 1'b1;
          rd_cnt  = 3;
          rd_fail = (blk_seen[gi] == err_blk[gi]);
          blk_seen[gi]++;
        end
        if (ram_we_w[gi]) begin
          run_cur[gi]++;
          if (run_cur[gi] > run_max[gi]) run_max[gi] = run_cur[gi];
          if (exp_wr[gi].size() == 0) check("wr_extra", ram_we_w[gi], 0);
          else begin
            e = exp_wr[gi].pop_front();
            check("wr_addr", ram_addr_w[gi], e[23:0]);
            check("wr_data", wdata8, e[31:24]);
          end
        end else begin
          run_cur[gi] = 0;
        end
      end
    end
  end

  task automatic start_load(input int inst, input int fid, input int eblk);
    int s     = 8 / P_DW[inst];
    int bw    = 512 * s;
    int words = P_FW[inst];
    int nblk;
    if (words > P_FB[inst] * bw) words = P_FB[inst] * bw;
    nblk = (words + bw - 1) / bw;
    if (eblk >= 0) begin
      nblk  = eblk + 1;
      words = eblk * bw;
    end
    exp_wr[inst].delete();
    exp_blk[inst].delete();
    for (int b = 0; b < nblk; b++) exp_blk[inst].push_back(32'(fid * P_FB[inst] + b));
    for (int w = 0; w < words; w++) begin
      int idx = (w / s) % 512;
      int d   = (int'(buf_byte(inst, idx)) >> ((w % s) * P_DW[inst])) & ((1 << P_DW[inst]) - 1);
      exp_wr[inst].push_back({8'(d), 24'(w)});
    end
    err_blk[inst]  = eblk;
    blk_seen[inst] = 0;
    run_cur[inst]  = 0;
    run_max[inst]  = 0;
    file_id[inst]    = 16'(fid);
    load_start[inst] = 1'b1;
    @(negedge clk_spi);
    load_start[inst] = 1'b0;
    $display("inst %0d: load file %0d, %0d writes expected", inst, fid, words);
  endtask

  task automatic wait_end(input int inst);
    int c = 0;
    while (!(done_w[inst] || error_w[inst]) && c < BUDGET) begin
      @(negedge clk_spi);
      c++;
    end
    check("end_timeout", 64'(c < BUDGET), 1);
  endtask

  task automatic wait_write(input int inst);
    int c = 0;
    while (!ram_we_w[inst] && c < BUDGET) begin
      @(negedge clk_spi);
      c++;
    end
    check("write_timeout", 64'(c < BUDGET), 1);
  endtask

  task automatic end_checks(input int inst, input bit ok, input int addr);
    check("busy_end", busy_w[inst], 0);
    check("done_end", done_w[inst], ok);
    check("error_end", error_w[inst], !ok);
    check("ram_addr_end", ram_addr_w[inst], addr);
    check("writes_left", exp_wr[inst].size(), 0);
    check("blks_left", exp_blk[inst].size(), 0);
    $display("inst %0d: load end done=%0b error=%0b ram_addr=%0d",
             inst, done_w[inst], error_w[inst], ram_addr_w[inst]);
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      err_blk[i] = -1;
      blk_seen[i] = 0;
      run_cur[i] = 0;
      run_max[i] = 0;
    end
    repeat (3) @(negedge clk_spi);
    check("rst_busy", busy_w[0], 0);
    check("rst_done", done_w[0], 0);
    check("rst_error", error_w[0], 0);
    check("rst_blk_req", g_inst[0].blk_req, 0);
    check("rst_blk_id", g_inst[0].blk_id, 0);
    check("rst_ram_we", ram_we_w[0], 0);
    reset_n = 1'b1;
    @(negedge clk_spi);

    // Full two-block load at blocks 6,7
    start_load(0, 3, -1);
    wait_end(0);
    end_checks(0, 1'b1, 8192);
    check("run_dw1", run_max[0], 4096);

    // Nibble unpack, one block, gap-free stream
    start_load(1, 0, -1);
    wait_end(1);
    end_checks(1, 1'b1, 1024);
    check("run_dw4", run_max[1], 1024);

    // Frame limit mid-block 1
    start_load(2, 1, -1);
    wait_end(2);
    end_checks(2, 1'b1, 5000);

    // Block read failure on block 1
    start_load(0, 2, 1);
    wait_end(0);
    end_checks(0, 1'b0, 4096);

    // Restart after error; start pulse and file_id change mid-copy are ignored
    start_load(0, 1, -1);
    wait_write(0);
    repeat (50) @(negedge clk_spi);
    file_id[0]    = 16'd9;
    load_start[0] = 1'b1;
    @(negedge clk_spi);
    load_start[0] = 1'b0;
    wait_end(0);
    end_checks(0, 1'b1, 8192);

    // Asynchronous reset in the middle of a copy
    start_load(0, 4, -1);
    wait_write(0);
    repeat (300) @(negedge clk_spi);
    #2 reset_n = 1'b0;
    #1;
    check("arst_busy", busy_w[0], 0);
    check("arst_ram_we", ram_we_w[0], 0);
    check("arst_ram_addr", ram_addr_w[0], 0);
    check("arst_wdata", g_inst[0].wdata8, 0);
    check("arst_buf_addr", g_inst[0].buf_addr, 0);
    check("arst_blk_id", g_inst[0].blk_id, 0);
    check("arst_done", done_w[0], 0);
    $display("inst 0: reset asserted mid-copy");
    exp_wr[0].delete();
    exp_blk[0].delete();
    @(negedge clk_spi);
    reset_n = 1'b1;
    repeat (40) @(negedge clk_spi);
    check("post_rst_busy", busy_w[0], 0);
    check("post_rst_addr", ram_addr_w[0], 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
